imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter MAX_WORDS, default 256, meaning largest accepted program length in words (at most 2**ADDR_W).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port res  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports in_valid  input  1, in_data  input  8, in_ready  output  1: byte stream from the host, transferred on a cycle with in_valid && in_ready.
REQ-006 SHALL have ports imem_we  output  1, imem_addr  output  ADDR_W, imem_wdata  output  32: word-write port into the instruction memory.
REQ-007 SHALL have port cpu_res  output  1  active-high reset driven to the mips core.
REQ-008 SHALL have ports done  output  1 (load complete) and err  output  1 (load rejected).

Function
REQ-009 SHALL implement states LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
REQ-010 Stream format SHALL be: 16-bit word count N, high byte first, then 4*N program bytes, big-endian per word (first byte is bits 31:24).
REQ-011 in_ready SHALL be 1 in LEN_HI, LEN_LO, DATA and CSUM, and 0 in DONE and ERR.
REQ-012 On a transfer in LEN_LO: N=0 SHALL go to CSUM if CHECKSUM_EN is defined, else to DONE; N>MAX_WORDS SHALL go to ERR; otherwise to DATA.
REQ-013 In DATA, a 2-bit byte counter SHALL assemble bytes; on the 4th transfer the word SHALL be presented on imem_wdata with imem_we=1 for exactly the next cycle.
REQ-014 imem_addr SHALL start at 0 and increment by 1 after each write; the first word goes to address 0.
REQ-015 After the Nth write, state SHALL go to CSUM (CHECKSUM_EN) or DONE.
REQ-016 A cycle with in_valid=0 SHALL leave all state, counters and the partial word unchanged (no timeout).
REQ-017 cpu_res SHALL be 1 in every state except DONE; in DONE it SHALL be 0.
REQ-018 done SHALL be 1 only in DONE, and err only in ERR; DONE and ERR SHALL be held until reset.
REQ-019 imem_we SHALL never be 1 in LEN_HI, LEN_LO, CSUM, DONE or ERR, except for the single write cycle that follows the final DATA transfer.
REQ-020 The word counter SHALL be 16 bits wide so that N up to 65535 is compared without overflow.

Reset
REQ-021 When res=0 at a clock edge: state SHALL be LEN_HI; counters, address and checksum SHALL be 0; imem_we, done and err SHALL be 0; cpu_res SHALL be 1.
REQ-022 A reset in the middle of a load SHALL discard the partial word and SHALL NOT produce a write.
REQ-023 Already-written memory contents SHALL be left as they are.

Configuration
REQ-024 Macro IMEM_LOADER_CHECKSUM_EN defined: an 8-bit running sum SHALL be taken over all bytes, including the count bytes, plus one trailing checksum byte accepted in CSUM.
- A total of 0 mod 256 SHALL go to DONE.
- Any other total SHALL go to ERR.
REQ-025 Macro undefined: there SHALL be no CSUM state, no sum register and no trailing byte; DATA or N=0 SHALL go directly to DONE.

Structure
REQ-026 A shared package mips_pkg SHALL hold the state enum typedef loader_state_t and the constant LOADER_LEN_BYTES=2.
REQ-027 Byte-to-word assembly SHALL be one sub-module, byte_packer: it shifts bytes in and flags word_ready on the 4th byte.
REQ-028 The top SHALL instantiate byte_packer once and hold the FSM and counters.

Verification
REQ-029 Reset, then stream 00 02 | 20080005 | 2009000A at one byte per cycle (undefined build) -> writes at addr 0 (0x20080005) and addr 1 (0x2009000A), done=1, cpu_res=0.
REQ-030 Same stream with in_valid toggling 0/1 every cycle -> identical writes and final state, and no extra writes.
REQ-031 Count bytes 00 00 -> no writes; undefined build reaches DONE; CSUM build with checksum byte 00 reaches DONE.
REQ-032 Count 0x0101 with MAX_WORDS=256 -> err=1, in_ready=0, cpu_res=1, no writes.
REQ-033 CSUM build: 00 01 | 00000001, then checksum FE -> done=1; the same stream with checksum FF -> err=1.
REQ-034 res=0 asserted after 2 of 4 data bytes, then a fresh stream 00 01 | AABBCCDD -> single write of 0xAABBCCDD at addr 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared loader definitions: FSM state encoding, stream header length and
// the 8-bit running-sum helper used by the optional checksum feature
// (macro IMEM_LOADER_CHECKSUM_EN).
package mips_pkg;

    localparam int LOADER_LEN_BYTES = 2;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM   = 3'd3,
`endif
        DONE   = 3'd4,
        ERR    = 3'd5
    } loader_state_t;

    // Modulo-256 accumulation of one stream byte
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port of the loader.
// master: host/memory side, slave: the loader itself.
interface imem_loader_if #(parameter int ADDR_W = 8);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output in_valid, output in_data, input in_ready,
                    input imem_we, input imem_addr, input imem_wdata);
    modport slave  (input in_valid, input in_data, output in_ready,
                    output imem_we, output imem_addr, output imem_wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Shifts bytes in MSB-first and flags word_ready on the 4th byte of a word.
// The full word is available combinationally alongside word_ready.
module byte_packer (
    input  logic        clk,
    input  logic        res,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    // Next byte index and shift contents; idle cycles hold the partial word
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (byte_valid) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_in};
        end else begin
            cnt_d   = cnt_q;
            shift_d = shift_q;
        end
    end

    assign word       = {shift_q, byte_in};
    assign word_ready = byte_valid && (cnt_q == 2'd3);

    // Packer registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed big-endian byte
// stream, writes one 32-bit word per 4 bytes, then releases the core reset.
// Optional trailing checksum byte enabled by macro IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic         clk,
    input  logic         res,
    imem_loader_if.slave bus,
    output logic         cpu_res,
    output logic         done,
    output logic         err
);
    localparam logic [16:0] MAX_W17 = 17'(MAX_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t END_ST = CSUM;
`else
    localparam loader_state_t END_ST = DONE;
`endif

    loader_state_t     state_q, state_d;
    logic [15:0]       len_q, len_d, new_len_s;
    logic [15:0]       wcnt_q, wcnt_d, wnext_s;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_res_q, cpu_res_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic        xfer_s;
    logic        pk_valid_s;
    logic [31:0] pk_word_s;
    logic        pk_ready_s;

    assign xfer_s     = bus.in_valid && in_ready_q;
    assign pk_valid_s = xfer_s && (state_q == DATA);
    assign new_len_s  = {len_q[15:8], bus.in_data};
    assign wnext_s    = wcnt_q + 16'd1;

    byte_packer u_packer (
        .clk        (clk),
        .res        (res),
        .byte_valid (pk_valid_s),
        .byte_in    (bus.in_data),
        .word       (pk_word_s),
        .word_ready (pk_ready_s)
    );

    // FSM next state, counters and next values of all registered outputs
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        if (we_q) begin
            addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            addr_d = addr_q;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (xfer_s) begin
            sum_d = sum8(sum_q, bus.in_data);
        end else begin
            sum_d = sum_q;
        end
`endif
        case (state_q)
            LEN_HI: begin
                if (xfer_s) begin
                    len_d   = {bus.in_data, 8'h00};
                    state_d = LEN_LO;
                end else begin
                    state_d = LEN_HI;
                end
            end
            LEN_LO: begin
                if (xfer_s) begin
                    len_d = new_len_s;
                    if (new_len_s == 16'd0) begin
                        state_d = END_ST;
                    end else if ({1'b0, new_len_s} > MAX_W17) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = LEN_LO;
                end
            end
            DATA: begin
                if (pk_ready_s) begin
                    we_d    = 1'b1;
                    wdata_d = pk_word_s;
                    wcnt_d  = wnext_s;
                    if (wnext_s == len_q) begin
                        state_d = END_ST;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (xfer_s) begin
                    if (sum8(sum_q, bus.in_data) == 8'h00) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    state_d = CSUM;
                end
            end
`endif
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = LEN_HI;
        endcase
        in_ready_d = (state_d != DONE) && (state_d != ERR);
        cpu_res_d  = (state_d != DONE);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q    <= LEN_HI;
            len_q      <= 16'd0;
            wcnt_q     <= 16'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            in_ready_q <= 1'b1;
            cpu_res_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wcnt_q     <= wcnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            in_ready_q <= in_ready_d;
            cpu_res_q  <= cpu_res_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_res        = cpu_res_q;
    assign done           = done_q;
    assign err            = err_q;
endmodule
